writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have parameter LANES, default 2, giving the number of issue lanes (1..4).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data width in bits (multiple of 16).
REQ-003 The block SHALL have parameter RAW, default 5, giving the register address width.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  input  1  sole clock, rising edge;
  reset  input  1  asynchronous, active-high;
  stall  input  1  hold the MEM/WB register;
  flush  input  1  invalidate captured lanes;
  valid_m  input  LANES  lane carries an instruction;
  regwrite_m  input  LANES  lane writes the register file;
  memtoreg_m  input  LANES  1 = load data, 0 = ALU result;
  loadtype_m  input  3*LANES  load format per lane;
  byteoff_m  input  2*LANES  address bits [1:0] per lane;
  aluout_m  input  WIDTH*LANES  ALU result per lane;
  readdata_m  input  WIDTH*LANES  raw memory word per lane;
  writereg_m  input  RAW*LANES  destination register per lane;
  valid_w  output  LANES  registered lane valid;
  regwrite_w  output  LANES  final write enable after suppression;
  writereg_w  output  RAW*LANES  registered destination;
  result_w  output  WIDTH*LANES  writeback data;
  retire_count  output  32  count of retired valid lanes.

Function
REQ-005 On a rising clk edge with stall=0 and flush=0, the block SHALL capture all _m inputs into the MEM/WB register.
REQ-006 On a rising edge with flush=1, the block SHALL clear every valid bit, regardless of stall; flush takes priority over stall.
REQ-007 On a rising edge with stall=1 and flush=0, the MEM/WB register SHALL hold its contents.
REQ-008 Latency SHALL be one cycle: all _w outputs are combinational functions of the MEM/WB register only.
REQ-009 result_w per lane SHALL be the registered aluout when memtoreg=0, and the extracted load data when memtoreg=1.
REQ-010 Load extraction SHALL use little-endian byte lane byteoff.
  - 000: full word.
  - 001: byte, sign-extended.
  - 010: byte, zero-extended.
  - 011: halfword selected by byteoff[1], sign-extended.
  - 100: halfword selected by byteoff[1], zero-extended.
  - 101..111: treated as full word.
REQ-011 regwrite_w[i] SHALL equal valid_w[i] AND registered regwrite[i] AND (writereg[i] != 0), subject to REQ-012.
REQ-012 When lanes i<j both qualify under REQ-011 with equal writereg, regwrite_w[i] SHALL be forced 0; the highest lane (program-latest) wins.
REQ-013 retire_count SHALL increment on each rising edge by the number of set valid_w bits, provided stall=0.
  - A held (stalled) bundle SHALL be counted only once, on the edge at which it leaves.
  - Flush SHALL NOT retroactively remove bundles already counted.
REQ-014 retire_count SHALL wrap modulo 2^32 without saturation.

Reset
REQ-015 While reset=1, the block SHALL asynchronously clear all MEM/WB register fields and retire_count to 0.
REQ-016 During and after reset, all outputs SHALL read 0 until the first capture edge.
REQ-017 When reset is asserted mid-stall or mid-flush, it SHALL override both; the first edge after deassertion obeys REQ-005..007.

Structure
REQ-018 A shared package SHALL hold the loadtype encodings (LD_W, LD_B, LD_BU, LD_H, LD_HU) and the default LANES/WIDTH/RAW constants.
REQ-019 Load extraction SHALL be one sub-module, load_extract (inputs: loadtype, byteoff, word; output: data), instantiated once per lane via generate.
REQ-020 Lane-conflict suppression and retire counting SHALL live in writeback_stage itself.

Verification
REQ-021 Lane0 ALU op, memtoreg=0, aluout=0x12345678, reg 3, valid → the next cycle gives result_w[0]=0x12345678 and regwrite_w[0]=1.
REQ-022 Lane1 load readdata=0x80FF7F01:
  - LD_B, off=2 → 0xFFFFFFFF.
  - LD_BU, off=3 → 0x00000080.
  - LD_H, off=0 → 0x00007F01.
  - LD_HU, off=2 → 0x000080FF.
  - loadtype=110 → 0x80FF7F01.
REQ-023 Both lanes write reg 7 → regwrite_w=2'b10; both write reg 0 → regwrite_w=2'b00.
REQ-024 Capture a 2-valid bundle, hold stall=1 for 3 cycles, then release → retire_count rises by exactly 2 and outputs stay constant during the stall.
REQ-025 Assert flush and stall on the same edge → valid_w=0 and regwrite_w=0 next cycle; assert reset asynchronously mid-cycle → retire_count=0 and all outputs 0 immediately.
REQ-026 Preload retire_count to 0xFFFFFFFF via 2^32-1 retirements, or force it in the bench, then retire 2 lanes → 0x00000001.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: load format encodings and
// default pipeline geometry.
package writeback_stage_pkg;

    localparam int DEF_LANES = 2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_RAW   = 5;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } load_type_e;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Per-lane load data extraction: selects the addressed byte/halfword of a raw
// little-endian memory word and sign- or zero-extends it to WIDTH bits.
module load_extract
    import writeback_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       loadtype,
    input  logic [1:0]       byteoff,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] data
);

    logic [31:0] low32;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // A 16-bit datapath is zero-padded so byte offsets 2 and 3 stay addressable.
    if (WIDTH >= 32) begin : g_wide
        assign low32 = word[31:0];
    end else begin : g_narrow
        assign low32 = 32'(word);
    end

    always_comb begin
        case (byteoff)
            2'd0:    byte_sel = low32[7:0];
            2'd1:    byte_sel = low32[15:8];
            2'd2:    byte_sel = low32[23:16];
            default: byte_sel = low32[31:24];
        endcase
        half_sel = byteoff[1] ? low32[31:16] : low32[15:0];

        case (loadtype)
            LD_B:    data = WIDTH'($signed(byte_sel));
            LD_BU:   data = WIDTH'(byte_sel);
            LD_H:    data = WIDTH'($signed(half_sel));
            LD_HU:   data = WIDTH'(half_sel);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with per-lane load extraction, same-destination
// write suppression across lanes, and a running count of retired lanes.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int RAW   = DEF_RAW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [LANES-1:0]       valid_m,
    input  logic [LANES-1:0]       regwrite_m,
    input  logic [LANES-1:0]       memtoreg_m,
    input  logic [3*LANES-1:0]     loadtype_m,
    input  logic [2*LANES-1:0]     byteoff_m,
    input  logic [WIDTH*LANES-1:0] aluout_m,
    input  logic [WIDTH*LANES-1:0] readdata_m,
    input  logic [RAW*LANES-1:0]   writereg_m,
    output logic [LANES-1:0]       valid_w,
    output logic [LANES-1:0]       regwrite_w,
    output logic [RAW*LANES-1:0]   writereg_w,
    output logic [WIDTH*LANES-1:0] result_w,
    output logic [31:0]            retire_count
);

    logic [LANES-1:0]       valid_r;
    logic [LANES-1:0]       regwrite_r;
    logic [LANES-1:0]       memtoreg_r;
    logic [3*LANES-1:0]     loadtype_r;
    logic [2*LANES-1:0]     byteoff_r;
    logic [WIDTH*LANES-1:0] aluout_r;
    logic [WIDTH*LANES-1:0] readdata_r;
    logic [RAW*LANES-1:0]   writereg_r;
    logic [WIDTH*LANES-1:0] load_data;
    logic [LANES-1:0]       qualified;
    logic [31:0]            retired;

    // Counting uses the bundle currently in the register, so a stalled bundle
    // is counted exactly once, on the edge where it moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r      <= '0;
            regwrite_r   <= '0;
            memtoreg_r   <= '0;
            loadtype_r   <= '0;
            byteoff_r    <= '0;
            aluout_r     <= '0;
            readdata_r   <= '0;
            writereg_r   <= '0;
            retire_count <= '0;
        end else begin
            if (!stall) begin
                retire_count <= retire_count + retired;
            end
            if (flush) begin
                valid_r <= '0;
            end else if (!stall) begin
                valid_r    <= valid_m;
                regwrite_r <= regwrite_m;
                memtoreg_r <= memtoreg_m;
                loadtype_r <= loadtype_m;
                byteoff_r  <= byteoff_m;
                aluout_r   <= aluout_m;
                readdata_r <= readdata_m;
                writereg_r <= writereg_m;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        load_extract #(.WIDTH(WIDTH)) u_extract (
            .loadtype (loadtype_r[3*g +: 3]),
            .byteoff  (byteoff_r[2*g +: 2]),
            .word     (readdata_r[WIDTH*g +: WIDTH]),
            .data     (load_data[WIDTH*g +: WIDTH])
        );
        assign result_w[WIDTH*g +: WIDTH] = memtoreg_r[g] ? load_data[WIDTH*g +: WIDTH]
                                                          : aluout_r[WIDTH*g +: WIDTH];
    end

    assign valid_w    = valid_r;
    assign writereg_w = writereg_r;

    // A lane loses its write when any later lane writes the same register.
    always_comb begin
        qualified = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            qualified[i] = valid_r[i] & regwrite_r[i] & (writereg_r[i*RAW +: RAW] != '0);
        end
        regwrite_w = qualified;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (qualified[j] && (writereg_r[j*RAW +: RAW] == writereg_r[i*RAW +: RAW])) begin
                    regwrite_w[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        retired = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            retired = retired + 32'(valid_r[i]);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a lane-level reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_writeback_stage;

    localparam int LANES = 2;
    localparam int WIDTH = 32;
    localparam int RAW   = 5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   stall = 1'b0;
    logic                   flush = 1'b0;
    logic [LANES-1:0]       valid_m = '0;
    logic [LANES-1:0]       regwrite_m = '0;
    logic [LANES-1:0]       memtoreg_m = '0;
    logic [3*LANES-1:0]     loadtype_m = '0;
    logic [2*LANES-1:0]     byteoff_m = '0;
    logic [WIDTH*LANES-1:0] aluout_m = '0;
    logic [WIDTH*LANES-1:0] readdata_m = '0;
    logic [RAW*LANES-1:0]   writereg_m = '0;
    logic [LANES-1:0]       valid_w;
    logic [LANES-1:0]       regwrite_w;
    logic [RAW*LANES-1:0]   writereg_w;
    logic [WIDTH*LANES-1:0] result_w;
    logic [31:0]            retire_count;

    int checks = 0;
    int failures = 0;
    bit preload = 1'b0;

    always #5 clk = ~clk;

    writeback_stage #(.LANES(LANES), .WIDTH(WIDTH), .RAW(RAW)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .valid_m      (valid_m),
        .regwrite_m   (regwrite_m),
        .memtoreg_m   (memtoreg_m),
        .loadtype_m   (loadtype_m),
        .byteoff_m    (byteoff_m),
        .aluout_m     (aluout_m),
        .readdata_m   (readdata_m),
        .writereg_m   (writereg_m),
        .valid_w      (valid_w),
        .regwrite_w   (regwrite_w),
        .writereg_w   (writereg_w),
        .result_w     (result_w),
        .retire_count (retire_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per lane plus the retired-lane total.
    bit          m_valid [LANES] = '{default: 1'b0};
    bit          m_rw    [LANES] = '{default: 1'b0};
    bit          m_mtr   [LANES] = '{default: 1'b0};
    int unsigned m_lt    [LANES] = '{default: 0};
    int unsigned m_off   [LANES] = '{default: 0};
    logic [31:0] m_alu   [LANES] = '{default: '0};
    logic [31:0] m_rd    [LANES] = '{default: '0};
    int unsigned m_wr    [LANES] = '{default: 0};
    logic [31:0] m_count = '0;

    function automatic int unsigned live_lanes();
        int unsigned n = 0;
        for (int i = 0; i < LANES; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [31:0] extract(input int unsigned lt, input int unsigned off,
                                            input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            1:       return (b >= 32'd128)   ? b - 32'd256   : b;
            2:       return b;
            3:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            4:       return h;
            default: return w;
        endcase
    endfunction

    function automatic bit writes(input int i);
        return m_valid[i] && m_rw[i] && (m_wr[i] != 0);
    endfunction

    function automatic bit exp_regwrite(input int i);
        if (!writes(i)) return 1'b0;
        for (int j = i + 1; j < LANES; j++)
            if (writes(j) && m_wr[j] == m_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                m_valid[i] <= 1'b0; m_rw[i] <= 1'b0; m_mtr[i] <= 1'b0;
                m_lt[i] <= 0; m_off[i] <= 0; m_alu[i] <= '0; m_rd[i] <= '0; m_wr[i] <= 0;
            end
            m_count <= '0;
        end else begin
            m_count <= (preload ? 32'hFFFF_FFFF : m_count) + (stall ? 32'd0 : 32'(live_lanes()));
            for (int i = 0; i < LANES; i++) begin
                if (flush) begin
                    m_valid[i] <= 1'b0;
                end else if (!stall) begin
                    m_valid[i] <= valid_m[i];
                    m_rw[i]    <= regwrite_m[i];
                    m_mtr[i]   <= memtoreg_m[i];
                    m_lt[i]    <= int'(loadtype_m[3*i +: 3]);
                    m_off[i]   <= int'(byteoff_m[2*i +: 2]);
                    m_alu[i]   <= aluout_m[WIDTH*i +: WIDTH];
                    m_rd[i]    <= readdata_m[WIDTH*i +: WIDTH];
                    m_wr[i]    <= int'(writereg_m[RAW*i +: RAW]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("valid_w[%0d]", i), 32'(valid_w[i]), 32'(m_valid[i]));
            check($sformatf("regwrite_w[%0d]", i), 32'(regwrite_w[i]), 32'(exp_regwrite(i)));
            check($sformatf("writereg_w[%0d]", i), 32'(writereg_w[RAW*i +: RAW]), m_wr[i]);
            check($sformatf("result_w[%0d]", i), result_w[WIDTH*i +: WIDTH],
                  m_mtr[i] ? extract(m_lt[i], m_off[i], m_rd[i]) : m_alu[i]);
        end
        check("retire_count", retire_count, m_count);
    end

    task automatic set_lane(input int i, input bit v, input bit rw, input bit mtr,
                            input logic [2:0] lt, input logic [1:0] off,
                            input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
        valid_m[i] = v;
        regwrite_m[i] = rw;
        memtoreg_m[i] = mtr;
        loadtype_m[3*i +: 3] = lt;
        byteoff_m[2*i +: 2] = off;
        aluout_m[WIDTH*i +: WIDTH] = alu;
        readdata_m[WIDTH*i +: WIDTH] = rd;
        writereg_m[RAW*i +: RAW] = wr;
    endtask

    task automatic clear_inputs();
        stall = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < LANES; i++) set_lane(i, 0, 0, 0, 3'd0, 2'd0, '0, '0, 5'd0);
    endtask

    logic [2:0]  ld_lt  [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    logic [1:0]  ld_off [5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01,
                                32'h0000_80FF, 32'h80FF_7F01};

    logic [4:0]  cf_wr0 [5] = '{5'd7, 5'd0, 5'd3, 5'd0, 5'd7};
    logic [4:0]  cf_wr1 [5] = '{5'd7, 5'd0, 5'd8, 5'd5, 5'd7};
    bit          cf_rw1 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] cf_exp [5] = '{32'h2, 32'h0, 32'h3, 32'h2, 32'h1};

    logic [31:0] base;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_valid_w", 32'(valid_w), 32'h0);
        check("reset_result_w", result_w[31:0], 32'h0);
        check("reset_retire_count", retire_count, 32'h0);
        reset = 1'b0;

        // Single ALU lane.
        set_lane(0, 1, 1, 0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 5'd3);
        @(negedge clk);
        check("alu_result_w0", result_w[31:0], 32'h1234_5678);
        check("alu_regwrite_w", 32'(regwrite_w), 32'h1);

        // Load formats on lane 1.
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 1, 1, 0, 3'd0, 2'd0, 32'(k), 32'h0, 5'd4);
            set_lane(1, 1, 1, 1, ld_lt[k], ld_off[k], 32'hDEAD_BEEF, 32'h80FF_7F01, 5'd9);
            @(negedge clk);
            check($sformatf("load_result_w1_%0d", k), result_w[63:32], ld_exp[k]);
        end

        // Same-destination suppression.
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 1, 1, 0, 3'd0, 2'd0, 32'h11, 32'h0, cf_wr0[k]);
            set_lane(1, 1, cf_rw1[k], 0, 3'd0, 2'd0, 32'h22, 32'h0, cf_wr1[k]);
            @(negedge clk);
            check($sformatf("conflict_regwrite_w_%0d", k), 32'(regwrite_w), cf_exp[k]);
        end

        // Stall holds a two-lane bundle; it is counted once on release.
        set_lane(0, 1, 1, 0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0, 5'd10);
        set_lane(1, 1, 1, 0, 3'd0, 2'd0, 32'h0F0F_0F0F, 32'h0, 5'd11);
        @(negedge clk);
        base = m_count;
        stall = 1'b1;
        set_lane(0, 1, 1, 1, 3'd1, 2'd1, 32'h9999_9999, 32'h1234_5678, 5'd12);
        set_lane(1, 1, 1, 0, 3'd0, 2'd0, 32'h7777_7777, 32'h0, 5'd13);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_result_w", result_w[31:0], 32'hAAAA_5555);
            check("stall_result_w1", result_w[63:32], 32'h0F0F_0F0F);
            check("stall_valid_w", 32'(valid_w), 32'h3);
            check("stall_retire_count", retire_count, base);
        end
        clear_inputs();
        @(negedge clk);
        check("stall_release_retire", retire_count, base + 32'd2);

        // Flush wins over stall.
        set_lane(0, 1, 1, 0, 3'd0, 2'd0, 32'h1, 32'h0, 5'd1);
        set_lane(1, 1, 1, 0, 3'd0, 2'd0, 32'h2, 32'h0, 5'd2);
        @(negedge clk);
        flush = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        check("flush_valid_w", 32'(valid_w), 32'h0);
        check("flush_regwrite_w", 32'(regwrite_w), 32'h0);

        // Asynchronous reset in mid-cycle while stall and flush are high.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_retire_count", retire_count, 32'h0);
        check("async_valid_w", 32'(valid_w), 32'h0);
        check("async_regwrite_w", 32'(regwrite_w), 32'h0);
        check("async_writereg_w", 32'(writereg_w), 32'h0);
        check("async_result_w0", result_w[31:0], 32'h0);
        check("async_result_w1", result_w[63:32], 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        set_lane(0, 1, 1, 0, 3'd0, 2'd0, 32'h55, 32'h0, 5'd5);
        @(negedge clk);
        check("post_reset_valid_w", 32'(valid_w), 32'h1);
        check("post_reset_result_w0", result_w[31:0], 32'h55);
        check("post_reset_retire", retire_count, 32'h0);

        // Counter wrap from all-ones.
        clear_inputs();
        @(negedge clk);
        force dut.retire_count = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1;
        release dut.retire_count;
        set_lane(0, 1, 0, 0, 3'd0, 2'd0, 32'h3, 32'h0, 5'd6);
        set_lane(1, 1, 1, 0, 3'd0, 2'd0, 32'h4, 32'h0, 5'd6);
        @(posedge clk);
        #2;
        preload = 1'b0;
        @(negedge clk);
        check("wrap_preload", retire_count, 32'hFFFF_FFFF);
        clear_inputs();
        @(negedge clk);
        check("wrap_retire_count", retire_count, 32'h0000_0001);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
